mdu_unit: RTL
=============

// Module: mdu_unit
// PURPOSE
//   Multi-cycle multiply/divide unit in the EX stage. Owns HI/LO and raises busy while an op is in flight.
//   busy feeds the hazard/stall logic as MDUBusy; that logic stalls any MDU-class instruction in ID
//   (MDUreq) while busy=1 or start=1, so this block never needs to queue a second request.
// PARAMETERS
//   MULT_CYCLES  5   cycles busy is held for MULT/MULTU (>=1)
//   DIV_CYCLES   10  cycles busy is held for DIV/DIVU (>=1)
// PORTS
//   clk      in   1   rising-edge clock, the only clock
//   reset_n  in   1   asynchronous, active-low reset
//   start    in   1   EX-stage instruction is an MDU op; qualifies op
//   flush    in   1   EX instruction is cancelled (exception/interrupt); start is ignored this cycle
//   op       in   3   MDU_OP_* code, see the shared package
//   a        in   32  rs operand
//   b        in   32  rt operand
//   busy     out  1   operation in flight (registered)
//   hi       out  32  HI register (MFHI data)
//   lo       out  32  LO register (MFLO data)
// BEHAVIOUR
//   Reset: state=IDLE, cnt=0, busy=0, hi=0, lo=0, pending result regs=0. Async assert clears immediately,
//     including mid-operation; the in-flight result is discarded. Deassertion is synchronised upstream.
//   accept = start & ~flush & (state==IDLE). start while not IDLE is a protocol error (bench assertion); ignored.
//   FSM: IDLE -> MUL (accept, MULT/MULTU); IDLE -> DIV (accept, DIV/DIVU); MUL/DIV -> IDLE when cnt==1.
//   On accept of MULT/DIV: the 64-bit result is computed from a,b and captured in res_hi/res_lo.
//     cnt <= MULT_CYCLES or DIV_CYCLES.
//     In MUL/DIV: cnt decrements each cycle. On the cnt==1 edge hi<=res_hi, lo<=res_lo and state returns to IDLE.
//   Timing (accept sampled at edge E0): busy=1 for exactly N cycles after E0, then 0.
//     New hi/lo are visible in the same cycle busy falls. hi/lo keep old values while busy.
//   MULT: signed 32x32 -> {hi,lo}. MULTU: unsigned, both operands zero-extended to 64 bits.
//   DIV: lo=quotient truncated toward zero, hi=remainder with the sign of a.
//     0x80000000 / -1 gives lo=0x80000000, hi=0. DIVU: unsigned.
//   Divide by zero (b==0): the op still occupies DIV_CYCLES with busy=1; hi/lo are left unchanged.
//   MTHI/MTLO on accept: hi<=a (or lo<=a) at that edge, state stays IDLE, busy stays 0.
//   MDU_OP_NONE, or any unused code, on accept: no effect.
//   flush together with start: nothing is accepted and no register changes.
//     flush while busy does not abort the op; it completes normally.
// STRUCTURE
//   Shared package (mips_defs): MDU_OP_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6;
//     MDU state encodings IDLE/MUL/DIV.
//   Sub-module mdu_div_core (combinational): inputs a, b, is_signed; outputs quotient, remainder, div_zero.
//     Owns the sign-fixup rules above.
//   Top: FSM, counter sized $clog2(max(MULT_CYCLES,DIV_CYCLES)+1), result capture, HI/LO registers.
// TESTING
//   1 MULT a=0xFFFFFFFE(-2) b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//   2 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 in the cycle busy falls.
//   3 DIV a=-7 b=2 -> busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//     DIVU a=7 b=0 -> busy 10 cycles, hi/lo unchanged.
//   4 MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 on consecutive cycles -> hi/lo updated the next edge each, busy=0 throughout.
//   5 start=1 with flush=1, op=MULT -> busy stays 0, hi/lo unchanged.
//     Start DIV, then flush pulse mid-op -> DIV completes normally.
//   6 Start MULT, assert reset_n=0 at cycle 2 of busy -> busy=0, hi=lo=0 immediately.
//     After release, a MULT 3*4 gives lo=12 with correct 5-cycle busy.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS definitions: MDU opcodes and MDU state encodings.
package mips_defs;

    localparam logic [2:0] MDU_OP_NONE  = 3'd0;
    localparam logic [2:0] MDU_OP_MULT  = 3'd1;
    localparam logic [2:0] MDU_OP_MULTU = 3'd2;
    localparam logic [2:0] MDU_OP_DIV   = 3'd3;
    localparam logic [2:0] MDU_OP_DIVU  = 3'd4;
    localparam logic [2:0] MDU_OP_MTHI  = 3'd5;
    localparam logic [2:0] MDU_OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_MUL  = 2'd1,
        MDU_DIV  = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mdu_div_core.sv
// Combinational 32-bit divider with MIPS sign rules.
module mdu_div_core (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_zero
);

    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_ua;
    logic [31:0] w_ub;
    logic [31:0] w_ub_safe;
    logic [31:0] w_uq;
    logic [31:0] w_ur;

    assign w_a_neg   = is_signed & a[31];
    assign w_b_neg   = is_signed & b[31];
    assign w_ua      = w_a_neg ? -a : a;
    assign w_ub      = w_b_neg ? -b : b;
    assign div_zero  = (b == 32'd0);
    assign w_ub_safe = div_zero ? 32'd1 : w_ub;

    // 0x80000000 / -1 falls out naturally: magnitude wraps back to itself
    assign w_uq      = w_ua / w_ub_safe;
    assign w_ur      = w_ua % w_ub_safe;
    assign quotient  = (w_a_neg ^ w_b_neg) ? -w_uq : w_uq;
    assign remainder = w_a_neg ? -w_ur : w_ur;

endmodule

// File: rtl/mdu_unit.sv
// EX-stage multi-cycle multiply/divide unit owning HI/LO.
module mdu_unit
    import mips_defs::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        flush,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    mdu_state_t      r_state;
    mdu_state_t      w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            r_busy;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;
    logic [31:0]     r_res_hi;
    logic [31:0]     r_res_lo;
    logic            r_res_vld;

    logic            w_accept;
    logic            w_is_mul;
    logic            w_is_div;
    logic            w_done;
    logic            w_mul_sgn;
    logic [63:0]     w_ma;
    logic [63:0]     w_mb;
    logic [63:0]     w_prod;
    logic [31:0]     w_quot;
    logic [31:0]     w_rem;
    logic            w_dz;

    assign w_accept  = start & ~flush & (r_state == MDU_IDLE);
    assign w_is_mul  = (op == MDU_OP_MULT) | (op == MDU_OP_MULTU);
    assign w_is_div  = (op == MDU_OP_DIV) | (op == MDU_OP_DIVU);

    // low 64 bits of the extended product are exact for both signed and unsigned
    assign w_mul_sgn = (op == MDU_OP_MULT);
    assign w_ma      = {{32{w_mul_sgn & a[31]}}, a};
    assign w_mb      = {{32{w_mul_sgn & b[31]}}, b};
    assign w_prod    = w_ma * w_mb;

    mdu_div_core u_div (
        .a         (a),
        .b         (b),
        .is_signed (op == MDU_OP_DIV),
        .quotient  (w_quot),
        .remainder (w_rem),
        .div_zero  (w_dz)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done      = 1'b0;
        unique case (r_state)
            MDU_IDLE: begin
                if (w_accept && w_is_mul) begin
                    w_state_nxt = MDU_MUL;
                    w_cnt_nxt   = CW'(MULT_CYCLES);
                end else if (w_accept && w_is_div) begin
                    w_state_nxt = MDU_DIV;
                    w_cnt_nxt   = CW'(DIV_CYCLES);
                end
            end
            MDU_MUL, MDU_DIV: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = MDU_IDLE;
                    w_cnt_nxt   = '0;
                    w_done      = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = MDU_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= MDU_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt != MDU_IDLE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_res_hi  <= '0;
            r_res_lo  <= '0;
            r_res_vld <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            if (w_accept && w_is_mul) begin
                r_res_hi  <= w_prod[63:32];
                r_res_lo  <= w_prod[31:0];
                r_res_vld <= 1'b1;
            end else if (w_accept && w_is_div) begin
                r_res_hi  <= w_rem;
                r_res_lo  <= w_quot;
                r_res_vld <= ~w_dz;
            end
            // divide by zero leaves HI/LO untouched once the op retires
            if (w_done && r_res_vld) begin
                r_hi <= r_res_hi;
                r_lo <= r_res_lo;
            end else if (w_accept && op == MDU_OP_MTHI) begin
                r_hi <= a;
            end else if (w_accept && op == MDU_OP_MTLO) begin
                r_lo <= a;
            end
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
